// File: rtl/serial_adder_acc_if.sv
// Operand/result handshake bundle for serial_adder_acc.
// With SERIAL_ADDER_SUB_MODE_EN defined, the bundle carries the sub request.
interface serial_adder_acc_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADDER_SUB_MODE_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

`ifdef SERIAL_ADDER_SUB_MODE_EN
   modport master (output in_valid, a, b, cin, sub, out_ready,
                   input  in_ready, out_valid, sum, cout, ovf);
   modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                   output in_ready, out_valid, sum, cout, ovf);
`else
   modport master (output in_valid, a, b, cin, out_ready,
                   input  in_ready, out_valid, sum, cout, ovf);
   modport slave  (input  in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/serial_adder_acc.sv
// Bit-serial adder: one full-adder stage resolves one bit per enabled clock.
// Optional subtract mode is enabled by SERIAL_ADDER_SUB_MODE_EN.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   S_IDLE  | waiting for operands, in_ready high
//   S_SHIFT | resolving one bit per ena cycle, LSB first
//   S_DONE  | result presented, waiting for out_ready
module serial_adder_acc #(
   parameter int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   serial_adder_acc_if.slave  bus,
   output logic               busy
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sacc;
   logic             r_c;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic             w_s;
   logic             w_c;
   logic             w_last;
   logic             w_accept;
   logic [WIDTH-1:0] w_b_load;
   logic             w_c_load;

   assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
   assign w_c      = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_accept = ena && bus.in_valid && (r_state == S_IDLE);

`ifdef SERIAL_ADDER_SUB_MODE_EN
   // subtraction is a + ~b + 1; cin is ignored in that case
   assign w_b_load = bus.sub ? ~bus.b : bus.b;
   assign w_c_load = bus.sub ? 1'b1 : bus.cin;
`else
   assign w_b_load = bus.b;
   assign w_c_load = bus.cin;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else if (ena) r_state <= w_state_nxt;
   end

   // next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.in_valid) w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_last) w_state_nxt = S_DONE;
         S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // handshake and status outputs decoded from state
   always_comb begin
      bus.in_ready  = (r_state == S_IDLE);
      bus.out_valid = (r_state == S_DONE);
      busy          = (r_state == S_SHIFT) || (r_state == S_DONE);
   end

   // operand shift registers, carry and bit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_c    <= 1'b0;
         r_cnt  <= '0;
         r_sacc <= '0;
      end else if (w_accept) begin
         r_a   <= bus.a;
         r_b   <= w_b_load;
         r_c   <= w_c_load;
         r_cnt <= '0;
      end else if (ena && r_state == S_SHIFT) begin
         r_a    <= {1'b0, r_a[WIDTH-1:1]};
         r_b    <= {1'b0, r_b[WIDTH-1:1]};
         r_c    <= w_c;
         r_sacc <= {w_s, r_sacc[WIDTH-1:1]};
         r_cnt  <= r_cnt + CNT_W'(1);
      end
   end

   // result registers; loaded on the MSB edge, held until the next completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (ena && r_state == S_SHIFT && w_last) begin
         r_sum  <= {w_s, r_sacc[WIDTH-1:1]};
         r_cout <= w_c;
         r_ovf  <= r_c ^ w_c;
      end
   end

   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;
   assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_acc.sv
// Randomised bench for serial_adder_acc against an arithmetic reference.
module tb_serial_adder_acc;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b1;
   logic busy;

   serial_adder_acc_if #(.WIDTH(W)) bus ();

   serial_adder_acc #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus.slave),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] last_sum = '0;
   logic         last_cout = 1'b0;
   logic         last_ovf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive_sub(input logic s);
`ifdef SERIAL_ADDER_SUB_MODE_EN
      bus.sub = s;
`else
      if (s) $display("note: sub request ignored in add-only build");
`endif
   endtask

   // one full transaction: accept, optional ena gap, optional backpressure, drain
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, input int gap, input int bp);
      logic [W-1:0] bm;
      logic         cm;
      logic [W:0]   full;
      logic [W-1:0] e_sum;
      logic         e_cout, e_ovf;
      int t, cyc;
      bm = s ? ~b : b;
      cm = s ? 1'b1 : c;
      full = {1'b0, a} + {1'b0, bm} + {{W{1'b0}}, cm};
      e_sum  = full[W-1:0];
      e_cout = full[W];
      e_ovf  = (a[W-1] == bm[W-1]) && (e_sum[W-1] != a[W-1]);

      t = 0;
      while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
      chk("in_ready_idle", {31'b0, bus.in_ready}, 1);
      bus.a = a; bus.b = b; bus.cin = c; drive_sub(s); bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      drive_sub(1'($urandom));
      chk("busy_shift", {31'b0, busy}, 1);
      chk("in_ready_shift", {31'b0, bus.in_ready}, 0);
      chk("sum_hold", {24'b0, bus.sum}, {24'b0, last_sum});
      chk("cout_hold", {31'b0, bus.cout}, {31'b0, last_cout});

      cyc = 0;
      while (!bus.out_valid && cyc < 64) begin
         if (cyc == 3 && gap > 0) begin
            ena = 1'b0;
            repeat (gap) begin
               bus.in_valid = 1'($urandom);
               @(negedge clk);
               cyc++;
            end
            ena = 1'b1;
         end
         bus.in_valid = 1'($urandom);
         @(negedge clk);
         cyc++;
         chk("in_ready_busy", {31'b0, bus.in_ready}, 0);
      end
      bus.in_valid = 1'b0;
      chk("latency", cyc, W + gap);
      chk("sum", {24'b0, bus.sum}, {24'b0, e_sum});
      chk("cout", {31'b0, bus.cout}, {31'b0, e_cout});
      chk("ovf", {31'b0, bus.ovf}, {31'b0, e_ovf});

      repeat (bp) begin
         bus.in_valid = 1'($urandom);
         @(negedge clk);
         chk("bp_valid", {31'b0, bus.out_valid}, 1);
         chk("bp_sum", {24'b0, bus.sum}, {24'b0, e_sum});
         chk("bp_cout", {31'b0, bus.cout}, {31'b0, e_cout});
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("drain_valid", {31'b0, bus.out_valid}, 0);
      chk("drain_ready", {31'b0, bus.in_ready}, 1);
      chk("idle_sum", {24'b0, bus.sum}, {24'b0, e_sum});
      last_sum = e_sum; last_cout = e_cout; last_ovf = e_ovf;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      bus.out_ready = 1'b0; drive_sub(1'b0);
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 1);
      chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_sum", {24'b0, bus.sum}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 0);
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 0);
      run_op(8'h00, 8'h00, 1'b1, 1'b0, 0, 5);
      run_op(8'h12, 8'h34, 1'b0, 1'b0, 3, 0);

      // abort mid-SHIFT with in_valid held high through reset
      bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("abort_sum", {24'b0, bus.sum}, 0);
      chk("abort_cout", {31'b0, bus.cout}, 0);
      chk("abort_ovf", {31'b0, bus.ovf}, 0);
      chk("abort_valid", {31'b0, bus.out_valid}, 0);
      chk("abort_ready", {31'b0, bus.in_ready}, 1);
      chk("abort_busy", {31'b0, busy}, 0);
      repeat (2) @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", {31'b0, bus.in_ready}, 1);
      last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
      run_op(8'h80, 8'h80, 1'b0, 1'b0, 0, 0);

`ifdef SERIAL_ADDER_SUB_MODE_EN
      run_op(8'h05, 8'h07, 1'b1, 1'b1, 0, 0);
      run_op(8'h80, 8'h01, 1'b0, 1'b1, 0, 0);
`endif

      for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_ADDER_SUB_MODE_EN
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
`else
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
`endif
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/serial_adder_acc.md
Name: serial_adder_acc

Overview:
- Parametrised bit-serial adder: captures two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Resolves one bit per clock through a single registered full-adder stage.
- Presents sum, carry-out and signed overflow over a second valid/ready handshake.
- Successor to the single-bit combinational half adder: arbitrary width, carry-in, overflow, flow control, small-area serial datapath for tile-limited designs.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; low freezes all state.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- sub  in  1  subtract request; present only with SUB_MODE_EN.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of MSB stage.
- ovf  out  1  two's-complement overflow.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n low, async):
  - State IDLE; counter, operand shift registers and carry register cleared.
  - sum=0, cout=0, ovf=0, out_valid=0, busy=0.
  - in_ready=1; no capture occurs while rst_n is low.
- FSM states:
  - IDLE: in_ready=1. On an edge with in_valid & ena: load a, b into shift regs, carry reg <= cin, counter <= 0, go to SHIFT.
  - SHIFT: each edge with ena:
    - s = a0^b0^c; c <= majority(a0,b0,c).
    - Shift A/B right; shift s into MSB of the internal sum register; counter++.
    - On the edge where counter==WIDTH-1: capture carry-in of the MSB stage (c before update) for ovf, go to DONE.
    - On that same edge, load sum/cout/ovf output registers.
  - DONE: out_valid=1. On an edge with out_ready & ena: go to IDLE; out_valid drops the next cycle.
- Outputs:
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - sum/cout/ovf hold their last result until the next completion overwrites them, including through IDLE.
- Latency: out_valid rises exactly WIDTH ena-cycles after the accepting edge. Throughput is one result per WIDTH+2 cycles minimum (accept edge, WIDTH shift edges, drain edge); there is no overlap of operations.
- ovf = carry_into_MSB ^ cout.
- ena low:
  - No state, counter, register or output change; handshakes are ignored that cycle.
  - Latency extends by the number of ena-low cycles.
- Boundary conditions:
  - in_valid asserted during SHIFT/DONE: ignored (in_ready=0); the operand must be held by the source.
  - out_ready high in IDLE/SHIFT: no effect.
  - Reset mid-SHIFT or mid-DONE: operation aborted, everything returns to reset values immediately; no partial result is visible.
  - Operands change after capture: no effect on the in-flight result.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_MODE_EN.
- Defined:
  - sub port exists and is sampled with the operands on the accepting edge.
  - If sub=1: B is captured inverted, carry reg <= 1, cin ignored. Result is a-b; cout=1 means no borrow; ovf is signed overflow of the subtraction.
  - If sub=0: behaviour is identical to the undefined case.
- Undefined: sub port absent; add only; no inversion logic synthesised.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0 -> after 8 cycles sum=0x96, cout=0, ovf=1; in_ready=0 throughout SHIFT/DONE.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0, ovf=0; the first result holds in IDLE until the second completes.
- Backpressure: out_ready low 5 cycles after out_valid -> out_valid, sum, cout stay stable; in_valid pulses ignored; out_ready=1 -> IDLE next edge.
- ena low 3 cycles mid-SHIFT (a=0x12, b=0x34) -> out_valid rises after 11 cycles instead of 8; sum=0x46.
- Reset asserted after 4 SHIFT cycles -> all outputs immediately 0, state IDLE. Subsequent a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
- SERIAL_ADDER_SUB_MODE_EN, sub=1, a=0x05, b=0x07, cin=1 -> sum=0xFE, cout=0, ovf=0. Then sub=1, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
